// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module : vga_scanout
// Walks a 1-bit framebuffer in raster order with VGA timing and runs a
// frame-ready/ack handshake so only completed frames are displayed.
// Rev    : 1.0
// ============================================================================
module vga_scanout #(
    parameter int PIX_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] fb_row,
    output logic [11:0] fb_col,
    input  logic        fb_data,
    input  logic        frame_ready,
    output logic        frame_ack,
    output logic        fb_busy,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        pixel
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(PIX_DIV - 1);
    localparam logic [11:0] c_h_act    = 12'(H_ACTIVE);
    localparam logic [11:0] c_h_last   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] c_hs_start = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_hs_end   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] c_v_act    = 12'(V_ACTIVE);
    localparam logic [11:0] c_v_last   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] c_vs_start = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_vs_end   = 12'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    logic [DIV_W-1:0] div_q, div_d;
    logic [11:0]      h_q, h_d;
    logic [11:0]      v_q, v_d;
    state_t           state_q;
    logic             shown_q;
    logic             ack_q;
    logic             de_q, pixel_q, hsync_q, vsync_q;

    logic w_tick;
    logic w_active;
    logic w_vblank_start;

    assign w_tick         = (div_q == c_div_last);
    assign w_active       = (h_q < c_h_act) && (v_q < c_v_act);
    assign w_vblank_start = w_tick && (h_q == 12'd0) && (v_q == c_v_act);

    always_comb begin
        div_d = w_tick ? '0 : div_q + DIV_W'(1);
        h_d   = h_q;
        v_d   = v_q;
        if (w_tick) begin
            if (h_q == c_h_last) begin
                h_d = '0;
                v_d = (v_q == c_v_last) ? '0 : v_q + 12'd1;
            end else begin
                h_d = h_q + 12'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    // Blanking addresses park at 0 so the memory always sees a legal address.
    assign fb_row  = w_active ? v_q : 12'd0;
    assign fb_col  = w_active ? h_q : 12'd0;
    assign fb_busy = ~rst & (v_q < c_v_act);

    always_ff @(posedge clk) begin
        if (rst) begin
            de_q    <= 1'b0;
            pixel_q <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else if (w_tick) begin
            de_q    <= w_active;
            pixel_q <= w_active & shown_q & fb_data;
            hsync_q <= ~((h_q >= c_hs_start) && (h_q < c_hs_end));
            vsync_q <= ~((v_q >= c_vs_start) && (v_q < c_vs_end));
        end
    end

    // Handshake is only honoured at the first tick of vblank to avoid tearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shown_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_vblank_start && frame_ready) begin
                        ack_q   <= 1'b1;
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    shown_q <= 1'b1;
                    state_q <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (w_vblank_start && frame_ready) begin
                        ack_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign frame_ack = ack_q;
    assign de        = de_q;
    assign pixel     = pixel_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_scanout
// Randomized bench for vga_scanout using a reduced raster geometry and a
// model driven by the global pixel-tick index since reset release.
// Rev    : 1.0
// ============================================================================
module tb_vga_scanout;

    localparam int PD = 2;
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic [29:0] RST_VEC = {6'b001100, 24'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_ready = 1'b0;
    logic        fb_data;
    logic        frame_ack, fb_busy, hsync, vsync, de, pixel;
    logic [11:0] fb_row, fb_col;
    logic [29:0] act_vec;

    bit mem [0:VA-1][0:HA-1];
    bit all_ones = 1'b0;

    int tests = 0;
    int fails = 0;

    int   n = 0;
    logic e_ack = 1'b0, e_shown = 1'b0, e_de = 1'b0, e_pix = 1'b0;
    logic e_hs = 1'b1, e_vs = 1'b1;

    vga_scanout #(
        .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .fb_row(fb_row), .fb_col(fb_col), .fb_data(fb_data),
        .frame_ready(frame_ready), .frame_ack(frame_ack), .fb_busy(fb_busy),
        .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel)
    );

    always #5 clk = ~clk;

    always_comb begin
        fb_data = 1'b0;
        if (all_ones)
            fb_data = 1'b1;
        else if (fb_row < 12'(VA) && fb_col < 12'(HA))
            fb_data = mem[fb_row][fb_col];
    end

    assign act_vec = {de, pixel, hsync, vsync, frame_ack, fb_busy, fb_row, fb_col};

    function automatic bit memval(int r, int c);
        if (all_ones) return 1'b1;
        if (r < VA && c < HA) return mem[r][c];
        return 1'b0;
    endfunction

    // Tick k (k = 1, 2, ...) lands on clock edge k*PD and emits raster position k-1.
    always @(posedge clk) begin
        int k, p, h, v;
        bit act;
        if (rst) begin
            n <= 0; e_ack <= 1'b0; e_shown <= 1'b0;
            e_de <= 1'b0; e_pix <= 1'b0; e_hs <= 1'b1; e_vs <= 1'b1;
        end else begin
            k = n + 1;
            n <= k;
            e_ack <= 1'b0;
            e_shown <= e_shown | e_ack;
            if (k % PD == 0) begin
                p = k / PD - 1;
                h = p % HT;
                v = (p / HT) % VT;
                act = (h < HA) && (v < VA);
                e_de  <= act;
                e_pix <= act && e_shown && memval(v, h);
                e_hs  <= !(h >= HA + HF && h < HA + HF + HS);
                e_vs  <= !(v >= VA + VF && v < VA + VF + VS);
                e_ack <= (h == 0) && (v == VA) && frame_ready;
            end
        end
    end

    function automatic logic [29:0] exp_vec();
        int q, h, v;
        bit act;
        q = n / PD;
        h = q % HT;
        v = (q / HT) % VT;
        act = (h < HA) && (v < VA);
        return {e_de, e_pix, e_hs, e_vs, e_ack, (!rst && v < VA),
                act ? 12'(v) : 12'd0, act ? 12'(h) : 12'd0};
    endfunction

    function automatic int cur_row();
        return ((n / PD) / HT) % VT;
    endfunction

    task automatic fill_random();
        for (int r = 0; r < VA; r++)
            for (int c = 0; c < HA; c++)
                mem[r][c] = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (act_vec !== RST_VEC) begin
            fails++; $display("FAIL reset_values got=%h exp=%h", act_vec, RST_VEC);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (de !== 1'b0) begin
            fails++; $display("FAIL de_before_tick got=%b exp=0", de);
        end
        @(negedge clk);
        tests++;
        if (de !== 1'b1) begin
            fails++; $display("FAIL first_de_rise got=%b exp=1", de);
        end
    endtask

    task automatic test_timing();
        int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, px_cnt = 0;
        fill_random();
        for (int i = 0; i < FRAME * PD; i++) begin
            @(negedge clk);
            tests++;
            if (act_vec !== exp_vec()) begin
                fails++; $display("FAIL timing_stream n=%0d got=%h exp=%h", n, act_vec, exp_vec());
            end
            de_cnt += int'(de); hs_cnt += int'(!hsync); vs_cnt += int'(!vsync); px_cnt += int'(pixel);
        end
        tests++;
        if (de_cnt != HA * VA * PD) begin
            fails++; $display("FAIL de_per_frame got=%0d exp=%0d", de_cnt, HA * VA * PD);
        end
        tests++;
        if (hs_cnt != HS * VT * PD) begin
            fails++; $display("FAIL hsync_low_per_frame got=%0d exp=%0d", hs_cnt, HS * VT * PD);
        end
        tests++;
        if (vs_cnt != VS * HT * PD) begin
            fails++; $display("FAIL vsync_low_per_frame got=%0d exp=%0d", vs_cnt, VS * HT * PD);
        end
        tests++;
        if (px_cnt != 0) begin
            fails++; $display("FAIL pixel_unshown got=%0d exp=0", px_cnt);
        end
    endtask

    task automatic test_diag();
        int acks = 0, ones = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int r = 0; r < VA; r++)
            for (int c = 0; c < HA; c++)
                mem[r][c] = (r == c);
        frame_ready = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 2 * FRAME * PD; i++) begin
            @(negedge clk);
            tests++;
            if (act_vec !== exp_vec()) begin
                fails++; $display("FAIL diag_stream n=%0d got=%h exp=%h", n, act_vec, exp_vec());
            end
            if (i < FRAME * PD) acks += int'(frame_ack);
            else                ones += int'(pixel);
        end
        tests++;
        if (acks != 1) begin
            fails++; $display("FAIL diag_first_ack got=%0d exp=1", acks);
        end
        tests++;
        if (ones != VA * PD) begin
            fails++; $display("FAIL diag_ones got=%0d exp=%0d", ones, VA * PD);
        end
    endtask

    task automatic test_blank_ones();
        int px_cnt = 0;
        all_ones = 1'b1;
        for (int i = 0; i < FRAME * PD; i++) begin
            @(negedge clk);
            tests++;
            if (act_vec !== exp_vec()) begin
                fails++; $display("FAIL blank_stream n=%0d got=%h exp=%h", n, act_vec, exp_vec());
            end
            if (de === 1'b0) begin
                tests++;
                if (pixel !== 1'b0) begin
                    fails++; $display("FAIL pixel_in_blank n=%0d got=%b exp=0", n, pixel);
                end
            end
            if (cur_row() >= VA) begin
                tests++;
                if (fb_busy !== 1'b0) begin
                    fails++; $display("FAIL busy_in_vblank n=%0d got=%b exp=0", n, fb_busy);
                end
            end
            px_cnt += int'(pixel);
            frame_ready = 1'($urandom_range(0, 1));
        end
        tests++;
        if (px_cnt != HA * VA * PD) begin
            fails++; $display("FAIL ones_frame got=%0d exp=%0d", px_cnt, HA * VA * PD);
        end
        all_ones = 1'b0;
    endtask

    task automatic test_ready_midframe();
        int early_acks = 0, acks = 0, ones = 0;
        rst = 1'b1;
        frame_ready = 1'b0;
        repeat (2) @(negedge clk);
        fill_random();
        rst = 1'b0;
        for (int i = 0; i < FRAME * PD; i++) begin
            @(negedge clk);
            tests++;
            if (act_vec !== exp_vec()) begin
                fails++; $display("FAIL midframe_stream n=%0d got=%h exp=%h", n, act_vec, exp_vec());
            end
            if (n / PD <= VA * HT) begin
                early_acks += int'(frame_ack);
                ones += int'(pixel);
            end
            acks += int'(frame_ack);
            if (n / PD == 5 * HT) frame_ready = 1'b1;
        end
        tests++;
        if (early_acks != 0) begin
            fails++; $display("FAIL ack_before_vblank got=%0d exp=0", early_acks);
        end
        tests++;
        if (ones != 0) begin
            fails++; $display("FAIL pixel_before_ack got=%0d exp=0", ones);
        end
        tests++;
        if (acks != 1) begin
            fails++; $display("FAIL ack_at_vblank got=%0d exp=1", acks);
        end
    endtask

    task automatic test_reset_mid();
        int budget = 2 * FRAME * PD;
        int ones = 0;
        while (((n / PD) % FRAME != 6 * HT + 12) && budget > 0) begin
            @(negedge clk);
            budget--;
            tests++;
            if (act_vec !== exp_vec()) begin
                fails++; $display("FAIL pre_reset_stream n=%0d got=%h exp=%h", n, act_vec, exp_vec());
            end
        end
        tests++;
        if (budget == 0) begin
            fails++; $display("FAIL reach_mid_frame got=timeout exp=reached");
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (act_vec !== RST_VEC) begin
            fails++; $display("FAIL reset_mid_values got=%h exp=%h", act_vec, RST_VEC);
        end
        rst = 1'b0;
        frame_ready = 1'b0;
        for (int i = 0; i < FRAME * PD; i++) begin
            @(negedge clk);
            tests++;
            if (act_vec !== exp_vec()) begin
                fails++; $display("FAIL post_reset_stream n=%0d got=%h exp=%h", n, act_vec, exp_vec());
            end
            ones += int'(pixel);
        end
        tests++;
        if (ones != 0) begin
            fails++; $display("FAIL pixel_after_reset got=%0d exp=0", ones);
        end
    endtask

    task automatic test_random();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        fill_random();
        rst = 1'b0;
        for (int i = 0; i < 3 * FRAME * PD; i++) begin
            @(negedge clk);
            tests++;
            if (act_vec !== exp_vec()) begin
                fails++; $display("FAIL random_stream n=%0d got=%h exp=%h", n, act_vec, exp_vec());
            end
            frame_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_diag();
        test_blank_ones();
        test_ready_midframe();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
